// File: rtl/dram_stream_arbiter.sv
// Round-robin burst arbiter sharing one MIG UI among two write and two read
// streams; DRAM_ARB_STATS_EN adds per-requester command counters.
module dram_stream_arbiter #(
  parameter int          BURST_LEN       = 16,
  parameter int          MAX_OUTSTANDING = 32,
  parameter int          FRAME_BEATS     = 28800,
  parameter logic [26:0] BASE_WR0        = 27'h0,
  parameter logic [26:0] BASE_WR1        = 27'h0100000,
  parameter logic [26:0] BASE_RD0        = 27'h0,
  parameter logic [26:0] BASE_RD1        = 27'h0100000,
  parameter int          ADDR_STEP       = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         calib_in,
  input  logic [127:0] wr0_tdata,
  input  logic         wr0_tvalid,
  input  logic         wr0_tlast,
  output logic         wr0_tready,
  input  logic [127:0] wr1_tdata,
  input  logic         wr1_tvalid,
  input  logic         wr1_tlast,
  output logic         wr1_tready,
  input  logic         rd0_prog_full,
  output logic [127:0] rd0_tdata,
  output logic         rd0_tvalid,
  input  logic         rd1_prog_full,
  output logic [127:0] rd1_tdata,
  output logic         rd1_tvalid,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [15:0]  app_wdf_mask,
  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         err_out
`ifdef DRAM_ARB_STATS_EN
  ,
  input  logic [1:0]   stat_sel,
  output logic [31:0]  stat_count
`endif
);

  localparam int BW  = $clog2(FRAME_BEATS);
  localparam int TW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = TW + 1;
  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam logic [26:0] STEP = 27'(ADDR_STEP);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t state, state_n;
  logic [1:0] ptr, ptr_n, owner, owner_n, pick;
  logic [BCW-1:0] burst, burst_n;
  logic [BW-1:0] beat [4];
  logic [CW-1:0] outst;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [TW-1:0] wptr, rptr;
  logic [3:0] req;
  logic [26:0] base_sel;
  logic [127:0] rd_data_q;
  logic issue, found, can_rd, push, pop, wrap, tlast_sel;

  assign can_rd = outst < CW'(MAX_OUTSTANDING);
  assign req[0] = calib_in & wr0_tvalid;
  assign req[1] = calib_in & wr1_tvalid;
  assign req[2] = calib_in & ~rd0_prog_full & can_rd;
  assign req[3] = calib_in & ~rd1_prog_full & can_rd;

  assign push = issue & owner[1];
  assign pop  = app_rd_data_valid & (outst != '0);

  assign app_wdf_mask = '0;
  assign rd0_tdata = rd_data_q;
  assign rd1_tdata = rd_data_q;

  always_comb begin
    base_sel = BASE_WR0;
    unique case (owner)
      2'd0: base_sel = BASE_WR0;
      2'd1: base_sel = BASE_WR1;
      2'd2: base_sel = BASE_RD0;
      2'd3: base_sel = BASE_RD1;
      default: base_sel = BASE_WR0;
    endcase
  end

  assign tlast_sel = owner[0] ? wr1_tlast : wr0_tlast;
  assign wrap = (beat[owner] == BW'(FRAME_BEATS - 1))
              | (~owner[1] & tlast_sel);

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    owner_n      = owner;
    burst_n      = burst;
    issue        = 1'b0;
    found        = 1'b0;
    pick         = ptr;
    app_en       = 1'b0;
    app_cmd      = 3'd0;
    app_addr     = base_sel + 27'(beat[owner]) * STEP;
    app_wdf_data = owner[0] ? wr1_tdata : wr0_tdata;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wr0_tready   = 1'b0;
    wr1_tready   = 1'b0;
    unique case (state)
      IDLE: begin
        for (int i = 0; i < 4; i++) begin
          if (!found && req[ptr + 2'(i)]) begin
            found = 1'b1;
            pick  = ptr + 2'(i);
          end
        end
        if (found) begin
          owner_n = pick;
          burst_n = '0;
          state_n = SERVE;
        end
      end
      SERVE: begin
        // writes need both UI queues ready so data and command go together
        issue = req[owner] & app_rdy & (owner[1] | app_wdf_rdy);
        if (issue) begin
          app_en  = 1'b1;
          app_cmd = {2'b00, owner[1]};
          burst_n = burst + BCW'(1);
          if (!owner[1]) begin
            app_wdf_wren = 1'b1;
            app_wdf_end  = 1'b1;
            wr0_tready   = ~owner[0];
            wr1_tready   = owner[0];
          end
        end
        if ((issue && burst_n == BCW'(BURST_LEN)) ||
            (!issue && !req[owner])) begin
          state_n = IDLE;
          ptr_n   = owner + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      burst      <= '0;
      for (int i = 0; i < 4; i++) beat[i] <= '0;
      outst      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      err_out    <= 1'b0;
      rd0_tvalid <= 1'b0;
      rd1_tvalid <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      burst <= burst_n;
      if (issue) beat[owner] <= wrap ? '0 : beat[owner] + BW'(1);
      if (push) begin
        tag_mem[wptr] <= owner[0];
        wptr <= wptr + TW'(1);
      end
      if (pop) rptr <= rptr + TW'(1);
      outst      <= outst + CW'(push) - CW'(pop);
      rd0_tvalid <= pop & ~tag_mem[rptr];
      rd1_tvalid <= pop & tag_mem[rptr];
      if (app_rd_data_valid) rd_data_q <= app_rd_data;
      if (app_rd_data_valid && outst == '0) err_out <= 1'b1;
    end
  end

`ifdef DRAM_ARB_STATS_EN
  logic [31:0] stat_cnt [4];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      if (issue && stat_cnt[owner] != 32'hFFFF_FFFF)
        stat_cnt[owner] <= stat_cnt[owner] + 32'd1;
      stat_count <= stat_cnt[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_dram_stream_arbiter.sv
// Bench for dram_stream_arbiter: vector table, directed corner sequences and
// random traffic against a queue-based stream/tag model with an in-order MIG.
module tb_dram_stream_arbiter;
  localparam int FB = 28800;
  localparam logic [26:0] B1 = 27'h0100000;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic calib_in = 1'b0;
  logic [127:0] wr0_tdata = '0, wr1_tdata = '0;
  logic wr0_tvalid = 1'b0, wr1_tvalid = 1'b0;
  logic wr0_tlast = 1'b0, wr1_tlast = 1'b0;
  logic wr0_tready, wr1_tready;
  logic rd0_prog_full = 1'b1, rd1_prog_full = 1'b1;
  logic [127:0] rd0_tdata, rd1_tdata;
  logic rd0_tvalid, rd1_tvalid;
  logic [26:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en;
  logic [127:0] app_wdf_data;
  logic app_wdf_wren, app_wdf_end;
  logic [15:0] app_wdf_mask;
  logic app_rdy = 1'b1, app_wdf_rdy = 1'b1;
  logic [127:0] app_rd_data = '0;
  logic app_rd_data_valid = 1'b0;
  logic err_out;

  dram_stream_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .calib_in(calib_in),
    .wr0_tdata(wr0_tdata), .wr0_tvalid(wr0_tvalid),
    .wr0_tlast(wr0_tlast), .wr0_tready(wr0_tready),
    .wr1_tdata(wr1_tdata), .wr1_tvalid(wr1_tvalid),
    .wr1_tlast(wr1_tlast), .wr1_tready(wr1_tready),
    .rd0_prog_full(rd0_prog_full), .rd0_tdata(rd0_tdata),
    .rd0_tvalid(rd0_tvalid),
    .rd1_prog_full(rd1_prog_full), .rd1_tdata(rd1_tdata),
    .rd1_tvalid(rd1_tvalid),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int due; logic [127:0] d; } ret_t;
  typedef struct {
    bit calib, w0v, pf0, pf1, rdy, wrdy;
    bit en; bit [2:0] cmd; bit [26:0] addr;
  } vec_t;

  int tests = 0, fails = 0, cyc = 0;
  bit mon_en = 0, ret_en = 1, rnd_en = 0;
  int tlast_beat = -1;
  int probe_n = -1; bit probe_hit; logic [26:0] probe_addr;

  int wbeat [2], rbeat [2], wcnt [2], rcnt [2], retcnt [2], nen;
  int tagq [$], log_q [$];
  ret_t mig_q [$], hold_q [$];
  bit exp_rv0, exp_rv1, exp_err;
  logic [127:0] exp_rd;

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      wbeat[i] = 0; rbeat[i] = 0; wcnt[i] = 0; rcnt[i] = 0; retcnt[i] = 0;
    end
    nen = 0;
    tagq.delete(); log_q.delete();
    exp_rv0 = 0; exp_rv1 = 0; exp_err = 0; exp_rd = '0;
  endfunction

  // Reference model: checks registered outputs, then consumes this cycle.
  task automatic monitor();
    int s; bit last; logic [26:0] ea; ret_t r;
    chk("rd0_tvalid", rd0_tvalid, exp_rv0);
    chk("rd1_tvalid", rd1_tvalid, exp_rv1);
    if (exp_rv0) chk("rd0_tdata", rd0_tdata, exp_rd);
    if (exp_rv1) chk("rd1_tdata", rd1_tdata, exp_rd);
    chk("err_out", err_out, exp_err);
    exp_rv0 = 0; exp_rv1 = 0;
    if (app_rd_data_valid) begin
      if (tagq.size() == 0) exp_err = 1;
      else begin
        s = tagq.pop_front();
        exp_rd = app_rd_data;
        if (s == 0) exp_rv0 = 1; else exp_rv1 = 1;
        retcnt[s]++;
      end
    end
    if (app_en) begin
      nen++;
      chk("app_rdy_at_issue", app_rdy, 1);
      s = (app_addr >= B1) ? 1 : 0;
      if (app_cmd == 3'd0) begin
        ea = (s == 1 ? B1 : 27'd0) + 27'(wbeat[s] * 8);
        chk("wr_addr", app_addr, ea);
        chk("wr_data", app_wdf_data, s == 1 ? wr1_tdata : wr0_tdata);
        chk("wr_handshake",
            {app_wdf_wren, app_wdf_end, wr0_tready, wr1_tready, app_wdf_rdy,
             (s == 1 ? wr1_tvalid : wr0_tvalid), calib_in},
            {2'b11, s == 0, s == 1, 3'b111});
        chk("wdf_mask", app_wdf_mask, 0);
        last = (s == 1) ? wr1_tlast : wr0_tlast;
        if (s == 0 && wcnt[0] == probe_n) begin
          probe_hit = 1; probe_addr = app_addr;
        end
        wbeat[s] = (last || wbeat[s] == FB - 1) ? 0 : wbeat[s] + 1;
        wcnt[s]++;
        log_q.push_back(s);
      end else begin
        chk("rd_cmd", app_cmd, 1);
        ea = (s == 1 ? B1 : 27'd0) + 27'(rbeat[s] * 8);
        chk("rd_addr", app_addr, ea);
        chk("rd_request",
            {(s == 1 ? rd1_prog_full : rd0_prog_full), tagq.size() < 32,
             calib_in, app_wdf_wren, wr0_tready, wr1_tready},
            6'b011000);
        rbeat[s] = (rbeat[s] == FB - 1) ? 0 : rbeat[s] + 1;
        rcnt[s]++;
        tagq.push_back(s);
        r.due = cyc + 20; r.d = r128();
        if (ret_en) mig_q.push_back(r); else hold_q.push_back(r);
        log_q.push_back(2 + s);
      end
    end else begin
      chk("idle_strobes",
          {app_wdf_wren, app_wdf_end, wr0_tready, wr1_tready}, 0);
      log_q.push_back(-1);
    end
  endtask

  task automatic tick();
    ret_t r;
    @(negedge clk_in);
    if (mon_en) monitor();
    @(posedge clk_in);
    #1;
    cyc++;
    if (mig_q.size() > 0 && mig_q[0].due <= cyc) begin
      r = mig_q.pop_front();
      app_rd_data_valid = 1'b1;
      app_rd_data = r.d;
    end else app_rd_data_valid = 1'b0;
    wr0_tdata = r128();
    wr1_tdata = r128();
    if (rnd_en) begin
      calib_in      = ($urandom % 50) != 0;
      wr0_tvalid    = ($urandom % 3) != 0;
      wr1_tvalid    = ($urandom % 3) != 0;
      wr0_tlast     = ($urandom % 64) == 0;
      wr1_tlast     = ($urandom % 64) == 0;
      rd0_prog_full = ($urandom % 8) == 0;
      rd1_prog_full = ($urandom % 8) == 0;
      app_rdy       = ($urandom % 5) != 0;
      app_wdf_rdy   = ($urandom % 5) != 0;
    end else begin
      wr0_tlast = (wcnt[0] == tlast_beat);
      wr1_tlast = 1'b0;
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    calib_in = 0; wr0_tvalid = 0; wr1_tvalid = 0;
    rd0_prog_full = 1; rd1_prog_full = 1;
    app_rdy = 1; app_wdf_rdy = 1;
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    model_clear();
    mon_en = 1;
  endtask

  vec_t vt [9];
  ret_t rr;
  int nbad, e;

  initial begin
    vt[0] = '{0, 1, 1, 1, 1, 1, 0, 3'd0, 27'd0};
    vt[1] = '{1, 0, 1, 1, 1, 1, 0, 3'd0, 27'd0};
    vt[2] = '{1, 1, 1, 1, 0, 1, 0, 3'd0, 27'd0};
    vt[3] = '{1, 1, 1, 1, 1, 0, 0, 3'd0, 27'd0};
    vt[4] = '{1, 1, 1, 1, 1, 1, 1, 3'd0, 27'd0};
    vt[5] = '{1, 0, 0, 1, 1, 1, 1, 3'd1, 27'd0};
    vt[6] = '{1, 0, 1, 0, 1, 1, 1, 3'd1, B1};
    vt[7] = '{1, 1, 0, 0, 1, 0, 0, 3'd0, 27'd0};
    vt[8] = '{1, 0, 0, 0, 0, 1, 0, 3'd0, 27'd0};

    // reset state
    do_reset();
    chk("reset_strobes",
        {app_en, app_wdf_wren, app_wdf_end, wr0_tready, wr1_tready,
         rd0_tvalid, rd1_tvalid, err_out}, 0);

    // single-cycle grant vectors
    ret_en = 0;
    for (int i = 0; i < 9; i++) begin
      do_reset();
      calib_in = vt[i].calib; wr0_tvalid = vt[i].w0v;
      rd0_prog_full = vt[i].pf0; rd1_prog_full = vt[i].pf1;
      app_rdy = vt[i].rdy; app_wdf_rdy = vt[i].wrdy;
      tick();
      chk($sformatf("vec%0d_app_en", i), app_en, vt[i].en);
      chk($sformatf("vec%0d_wr0_tready", i), wr0_tready,
          vt[i].en && vt[i].cmd == 3'd0);
      if (vt[i].en) begin
        chk($sformatf("vec%0d_cmd", i), app_cmd, vt[i].cmd);
        chk($sformatf("vec%0d_addr", i), app_addr, vt[i].addr);
      end
    end
    do_reset();
    hold_q.delete();
    ret_en = 1;

    // calibration gating
    do_reset();
    wr0_tvalid = 1;
    repeat (50) tick();
    chk("calib_gate_no_en", nen, 0);
    calib_in = 1;
    tick();
    chk("calib_first_en", app_en, 1);
    chk("calib_first_cmd", app_cmd, 0);
    chk("calib_first_addr", app_addr, 0);

    // burst rotation between both writers
    do_reset();
    calib_in = 1; wr0_tvalid = 1; wr1_tvalid = 1;
    repeat (60) tick();
    chk("rotation_len", log_q.size(), 60);
    nbad = 0;
    for (int k = 0; k < 60 && k < log_q.size(); k++) begin
      e = (k % 17 == 0) ? -1 : (k / 17) % 2;
      if (log_q[k] != e) nbad++;
    end
    chk("rotation_pattern_errors", nbad, 0);

    // tlast wrap mid-frame
    do_reset();
    calib_in = 1; wr0_tvalid = 1;
    tlast_beat = 100; probe_n = 101; probe_hit = 0;
    for (int k = 0; k < 400 && wcnt[0] < 102; k++) tick();
    chk("tlast_probe_hit", probe_hit, 1);
    chk("tlast_wrap_addr", probe_addr, 0);
    tlast_beat = -1;

    // full-frame wrap
    do_reset();
    calib_in = 1; wr0_tvalid = 1;
    probe_n = FB; probe_hit = 0;
    for (int k = 0; k < 40000 && wcnt[0] <= FB; k++) tick();
    chk("frame_probe_hit", probe_hit, 1);
    chk("frame_wrap_addr", probe_addr, 0);
    probe_n = -1;

    // outstanding limit with withheld returns
    do_reset();
    ret_en = 0;
    calib_in = 1; rd0_prog_full = 0;
    repeat (100) tick();
    chk("outstanding_cap", rcnt[0], 32);
    chk("outstanding_en_low", app_en, 0);
    rr = hold_q.pop_front(); rr.due = 0; mig_q.push_back(rr);
    repeat (60) tick();
    chk("outstanding_one_more", rcnt[0], 33);
    chk("outstanding_returned", retcnt[0], 1);

    // stray return after reset mid-flight
    do_reset();
    rr = hold_q.pop_front(); rr.due = 0; mig_q.push_back(rr);
    repeat (3) tick();
    chk("stray_err_set", err_out, 1);
    repeat (20) tick();
    chk("stray_err_sticky", err_out, 1);
    do_reset();
    chk("err_cleared_by_reset", err_out, 0);
    hold_q.delete();
    ret_en = 1;

    // random traffic against the model
    do_reset();
    rnd_en = 1;
    repeat (3000) tick();
    rnd_en = 0;
    calib_in = 0; wr0_tvalid = 0; wr1_tvalid = 0;
    repeat (80) tick();
    chk("rand_tags_drained", tagq.size(), 0);
    chk("rand_mig_drained", mig_q.size(), 0);
    chk("rand_all_streams_used",
        {wcnt[0] > 0, wcnt[1] > 0, retcnt[0] > 0, retcnt[1] > 0}, 4'hF);
    chk("rand_err_clear", err_out, 0);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
